frac_pwm_capture: RTL and testbench

//  Measures a PWM waveform, such as the fractional PWM generator output, and recovers its period, per-period high time and fractional duty.

---
 rtl/frac_pwm_capture_if.sv | 35 +++
 rtl/frac_pwm_capture.sv | 198 +++++++++++++++++++
 tb/tb_frac_pwm_capture.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frac_pwm_capture_if.sv
// Measurement bus of the fractional PWM capture block.
// Carries the PWM input plus period/high/duty results and status flags.
//   pwm_in                    : PWM waveform, asynchronous to the capture clock
//   period_o/high_o/per_valid : per-period measurement and its strobe
//   duty_int/duty_frac        : windowed average high time (Nf + m/M) and strobe
//   frac_valid                : strobe for duty_int/duty_frac
//   stuck/stuck_level         : no-edge status and the level the input stuck at
interface frac_pwm_capture_if #(
    parameter int WIDTH = 17,
    parameter int FSZE  = 6
);
    logic             pwm_in;
    logic [WIDTH-1:0] period_o;
    logic [WIDTH-1:0] high_o;
    logic             per_valid;
    logic [WIDTH-1:0] duty_int;
    logic [FSZE-1:0]  duty_frac;
    logic             frac_valid;
    logic             stuck;
    logic             stuck_level;

    modport master (
        input  pwm_in,
        output period_o, high_o, per_valid,
        output duty_int, duty_frac, frac_valid,
        output stuck, stuck_level
    );

    modport slave (
        output pwm_in,
        input  period_o, high_o, per_valid,
        input  duty_int, duty_frac, frac_valid,
        input  stuck, stuck_level
    );
endinterface

// File: rtl/frac_pwm_capture.sv
// Fractional PWM capture: measures period and high time of a PWM input and
// averages high time over 2^FSZE periods into integer + FSZE-bit fraction.
//   sys_clk : capture clock, rising edge
//   rst     : synchronous active-high reset
//   bus     : measurement bus (master side), see frac_pwm_capture_if
module frac_pwm_capture #(
    parameter int WIDTH = 17,
    parameter int FSZE  = 6,
    parameter int TMO   = (1 << WIDTH) - 1
) (
    input  logic                sys_clk,
    input  logic                rst,
    frac_pwm_capture_if.master  bus
);

    localparam int AW = WIDTH + FSZE;
    localparam logic [WIDTH-1:0] TMO_C  = WIDTH'(TMO);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEAS  = 2'd1,
        STUCK = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic             sync1_q, sync1_d;
    logic             s_q, s_d;
    logic             sd_q, sd_d;
    logic [WIDTH-1:0] cp_q, cp_d;
    logic [WIDTH-1:0] ch_q, ch_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [FSZE-1:0]  wcnt_q, wcnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic [WIDTH-1:0] duty_int_q, duty_int_d;
    logic [FSZE-1:0]  duty_frac_q, duty_frac_d;
    logic             per_valid_q, per_valid_d;
    logic             frac_valid_q, frac_valid_d;
    logic             stuck_q, stuck_d;
    logic             stuck_lvl_q, stuck_lvl_d;

    logic             rise;
    logic             tmo_hit;
    logic [AW-1:0]    acc_sum;

    assign rise    = s_q & ~sd_q;
    // a rise in the same cycle as the timeout takes precedence
    assign tmo_hit = (cp_q == TMO_C) & ~rise;
    assign acc_sum = acc_q + AW'(ch_q);

    // state register
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEAS;
                end else if (tmo_hit) begin
                    state_d = STUCK;
                end
            end
            MEAS: begin
                if (tmo_hit) begin
                    state_d = STUCK;
                end
            end
            STUCK: begin
                if (rise) begin
                    state_d = MEAS;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // output and datapath logic
    always_comb begin
        sync1_d      = bus.pwm_in;
        s_d          = sync1_q;
        sd_d         = s_q;
        acc_d        = acc_q;
        wcnt_d       = wcnt_q;
        period_d     = period_q;
        high_d       = high_q;
        duty_int_d   = duty_int_q;
        duty_frac_d  = duty_frac_q;
        per_valid_d  = 1'b0;
        frac_valid_d = 1'b0;
        stuck_d      = stuck_q;
        stuck_lvl_d  = stuck_lvl_q;

        if (rise) begin
            cp_d = CNT_ONE;
            ch_d = CNT_ONE;
        end else begin
            cp_d = (cp_q == CNT_MAX) ? cp_q : cp_q + CNT_ONE;
            ch_d = (ch_q == CNT_MAX) ? ch_q : ch_q + WIDTH'(s_q);
        end

        unique case (state_q)
            IDLE: begin
                if (tmo_hit) begin
                    stuck_d     = 1'b1;
                    stuck_lvl_d = s_q;
                    acc_d       = '0;
                    wcnt_d      = '0;
                end
            end
            MEAS: begin
                if (rise) begin
                    period_d    = cp_q;
                    high_d      = ch_q;
                    per_valid_d = 1'b1;
                    acc_d       = acc_sum;
                    wcnt_d      = wcnt_q + FSZE'(1);
                    // last period of the window: publish and restart
                    if (wcnt_q == '1) begin
                        duty_int_d   = acc_sum[AW-1:FSZE];
                        duty_frac_d  = acc_sum[FSZE-1:0];
                        frac_valid_d = 1'b1;
                        acc_d        = '0;
                        wcnt_d       = '0;
                    end
                end else if (tmo_hit) begin
                    stuck_d     = 1'b1;
                    stuck_lvl_d = s_q;
                    acc_d       = '0;
                    wcnt_d      = '0;
                end
            end
            STUCK: begin
                // this rise only opens a new period
                if (rise) begin
                    stuck_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            s_q          <= 1'b0;
            sd_q         <= 1'b0;
            cp_q         <= '0;
            ch_q         <= '0;
            acc_q        <= '0;
            wcnt_q       <= '0;
            period_q     <= '0;
            high_q       <= '0;
            duty_int_q   <= '0;
            duty_frac_q  <= '0;
            per_valid_q  <= 1'b0;
            frac_valid_q <= 1'b0;
            stuck_q      <= 1'b0;
            stuck_lvl_q  <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            s_q          <= s_d;
            sd_q         <= sd_d;
            cp_q         <= cp_d;
            ch_q         <= ch_d;
            acc_q        <= acc_d;
            wcnt_q       <= wcnt_d;
            period_q     <= period_d;
            high_q       <= high_d;
            duty_int_q   <= duty_int_d;
            duty_frac_q  <= duty_frac_d;
            per_valid_q  <= per_valid_d;
            frac_valid_q <= frac_valid_d;
            stuck_q      <= stuck_d;
            stuck_lvl_q  <= stuck_lvl_d;
        end
    end

    assign bus.period_o    = period_q;
    assign bus.high_o      = high_q;
    assign bus.per_valid   = per_valid_q;
    assign bus.duty_int    = duty_int_q;
    assign bus.duty_frac   = duty_frac_q;
    assign bus.frac_valid  = frac_valid_q;
    assign bus.stuck       = stuck_q;
    assign bus.stuck_level = stuck_lvl_q;

endmodule

// File: tb/tb_frac_pwm_capture.sv
// Testbench for frac_pwm_capture: waveform-level reference model feeding
// a scoreboard, with a monitor checking each per_valid/frac_valid pulse.
module tb_frac_pwm_capture;

    localparam int W   = 17;
    localparam int F   = 6;
    localparam int TMO = 500;
    localparam int M   = 1 << F;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    frac_pwm_capture_if #(.WIDTH(W), .FSZE(F)) bus ();

    frac_pwm_capture #(
        .WIDTH (W),
        .FSZE  (F),
        .TMO   (TMO)
    ) dut (
        .sys_clk (clk),
        .rst     (rst),
        .bus     (bus)
    );

    typedef struct {
        int a;
        int b;
        int t;
    } exp_t;

    exp_t pq[$];
    exp_t fq[$];

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // reference model state, in terms of the driven waveform
    bit   armed      = 0;
    bit   rise_valid = 0;
    bit   m_stuck    = 0;
    logic prev_lvl   = 1'b0;
    logic lvl_tmo    = 1'b0;
    int   since_rise = 0;
    int   cur_len    = 0;
    int   cur_h      = 0;
    int   win_sum    = 0;
    int   win_cnt    = 0;
    int   last_p     = 0;
    int   last_h     = 0;
    int   last_di    = 0;
    int   last_df    = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp_v, cyc);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (pq.size() != 0 && pq[0].t < cyc) begin
            n_vec++;
            n_fail++;
            $display("FAIL per_valid_missing: got none expected at cycle %0d",
                     pq[0].t);
            pq.delete(0);
        end
        if (fq.size() != 0 && fq[0].t < cyc) begin
            n_vec++;
            n_fail++;
            $display("FAIL frac_valid_missing: got none expected at cycle %0d",
                     fq[0].t);
            fq.delete(0);
        end
        if (bus.per_valid === 1'b1) begin
            if (pq.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL per_valid_extra: got pulse at %0d expected none",
                         cyc);
            end else begin
                e = pq[0];
                pq.delete(0);
                chk("period_o", int'(bus.period_o), e.a);
                chk("high_o", int'(bus.high_o), e.b);
                chk("per_valid_time", cyc, e.t);
            end
        end
        if (bus.frac_valid === 1'b1) begin
            if (fq.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL frac_valid_extra: got pulse at %0d expected none",
                         cyc);
            end else begin
                e = fq[0];
                fq.delete(0);
                chk("duty_int", int'(bus.duty_int), e.a);
                chk("duty_frac", int'(bus.duty_frac), e.b);
                chk("frac_valid_time", cyc, e.t);
            end
        end
    end

    // a rising edge closes the previous period, if one was open
    task automatic model_rise();
        if (armed && cur_len <= TMO) begin
            pq.push_back(exp_t'{cur_len, cur_h, cyc + 3});
            last_p = cur_len;
            last_h = cur_h;
            win_sum += cur_h;
            win_cnt++;
            if (win_cnt == M) begin
                last_di = win_sum / M;
                last_df = win_sum % M;
                fq.push_back(exp_t'{last_di, last_df, cyc + 3});
                win_sum = 0;
                win_cnt = 0;
            end
        end else begin
            win_sum = 0;
            win_cnt = 0;
        end
        armed      = 1;
        rise_valid = 1;
        since_rise = 0;
        cur_len    = 0;
        cur_h      = 0;
    endtask

    task automatic step(input logic lvl);
        if (lvl && !prev_lvl) model_rise();
        if (rise_valid && since_rise == TMO) lvl_tmo = lvl;
        cur_len++;
        if (lvl) cur_h++;
        prev_lvl   = lvl;
        bus.pwm_in = lvl;
        @(negedge clk);
        if (rise_valid) begin
            since_rise++;
            if (since_rise == 2)
                chk("stuck_before_rise_seen", int'(bus.stuck), int'(m_stuck));
            if (since_rise == 3) begin
                chk("stuck_after_rise", int'(bus.stuck), 0);
                m_stuck = 0;
            end
            if (since_rise == TMO + 2)
                chk("stuck_early", int'(bus.stuck), 0);
            if (since_rise == TMO + 3) begin
                chk("stuck_set", int'(bus.stuck), 1);
                chk("stuck_level", int'(bus.stuck_level), int'(lvl_tmo));
                chk("held_period", int'(bus.period_o), last_p);
                chk("held_high", int'(bus.high_o), last_h);
                chk("held_duty_int", int'(bus.duty_int), last_di);
                chk("held_duty_frac", int'(bus.duty_frac), last_df);
                m_stuck = 1;
            end
        end
    endtask

    task automatic run(input logic lvl, input int n);
        for (int i = 0; i < n; i++) step(lvl);
    endtask

    task automatic period(input int h, input int l);
        run(1'b1, h);
        run(1'b0, l);
    endtask

    task automatic rand_periods(input int n, input int pmax);
        for (int i = 0; i < n; i++) begin
            int p;
            int h;
            p = int'($urandom_range(pmax, 2));
            h = int'($urandom_range(p - 1, 1));
            period(h, p - h);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_period"}, int'(bus.period_o), 0);
        chk({name, "_high"}, int'(bus.high_o), 0);
        chk({name, "_duty_int"}, int'(bus.duty_int), 0);
        chk({name, "_duty_frac"}, int'(bus.duty_frac), 0);
        chk({name, "_flags"},
            int'({bus.per_valid, bus.frac_valid, bus.stuck, bus.stuck_level}), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        armed      = 0;
        rise_valid = 0;
        m_stuck    = 0;
        cur_len    = 0;
        cur_h      = 0;
        win_sum    = 0;
        win_cnt    = 0;
        last_p     = 0;
        last_h     = 0;
        last_di    = 0;
        last_df    = 0;
    endtask

    initial begin
        rst        = 1'b1;
        bus.pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_all_zero("reset");
        run(1'b0, 5);

        // steady 100/37
        for (int i = 0; i < 5; i++) period(37, 63);

        // 16 of 64 periods at 37, rest at 36
        for (int i = 0; i < 64; i++) begin
            if (i < 16) period(37, 63);
            else period(36, 64);
        end

        rand_periods(150, 60);

        // fastest legal input
        for (int i = 0; i < 70; i++) period(1, 1);

        // stuck high, then recover
        period(5, 5);
        run(1'b1, TMO + 10);
        run(1'b0, 3);
        rand_periods(10, 30);

        // stuck low, then recover
        run(1'b1, 4);
        run(1'b0, TMO + 10);
        rand_periods(100, 60);

        // reset mid-window while the input is low
        run(1'b1, 5);
        run(1'b0, 5);
        do_reset();
        chk_all_zero("midreset");
        run(1'b0, 5);
        rand_periods(66, 20);

        // close the last period and drain
        run(1'b1, 2);
        run(1'b0, 10);

        chk("per_queue_drained", pq.size(), 0);
        chk("frac_queue_drained", fq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
